gnn_result_streamer: RTL and testbench
======================================

// Module: gnn_result_streamer
// PURPOSE
//  Downstream stage of the GNN accelerator. It captures the 4-node x 2-output layer-2 MAC results
//  when every per-output ready flag is high. It then streams the 8 signed words out one per beat
//  over a valid/ready interface, with backpressure. A sticky overrun flag reports results lost
//  while a stream is in progress.
// PARAMETERS
//  DATA_W     21  width of each signed mac2 result word
//  NUM_NODES  4   number of graph nodes
//  NUM_OUT    2   outputs per node (neurons 8, 9)
// PORTS
//  clk         in   1                         clock, rising edge
//  rst_n       in   1                         asynchronous, active-low reset
//  res_data    in   NUM_NODES*NUM_OUT*DATA_W  packed results; word k = node*NUM_OUT+out, word 0 in LSBs
//  res_rdy     in   NUM_NODES*NUM_OUT         per-word ready flags (outXY_ready_nodeN), same indexing
//  m_valid     out  1                         stream beat valid
//  m_ready     in   1                         sink accepts beat
//  m_data      out  DATA_W                    signed result word
//  m_node      out  $clog2(NUM_NODES)         node index of current beat
//  m_out       out  $clog2(NUM_OUT)           output index of current beat
//  m_last      out  1                         high on final beat (node NUM_NODES-1, out NUM_OUT-1)
//  busy        out  1                         high while in STREAM
//  overrun     out  1                         sticky; a capture event was dropped
//  class_vec   out  NUM_NODES                 per-node argmax label (see CONFIGURATION)
//  class_vld   out  1                         one-cycle pulse when class_vec is updated
// BEHAVIOUR
//  Reset values: every output is 0, the capture buffer is 0, the beat index is 0, the state is IDLE,
//    and all_q is 0.
//  Capture event: all_rdy = &res_rdy; all_q = all_rdy registered; cap_ev = all_rdy & ~all_q.
//    The event is level-to-rising, so flags that are already high when reset is released give a
//    capture on the first cycle.
//  FSM IDLE -> STREAM on cap_ev: res_data is registered into the buffer and the index is set to 0.
//    m_valid is high from the next cycle (latency 1 clk from cap_ev to the first beat).
//  STREAM, per beat: beat = m_valid & m_ready. On each beat the index increments. On the beat
//    where m_last=1, the FSM returns to IDLE.
//  Beat order: n0o0, n0o1, n1o0, ..., n3o1. That is 8 beats, and with no stalls the stream takes
//    8 consecutive clocks.
//  Stall hold: while m_valid & ~m_ready, m_data, m_node, m_out and m_last must not change.
//  Each word is delivered bit-exact; no truncation and no sign change.
//  Last beat coinciding with cap_ev: the capture is accepted and the FSM stays in STREAM with the
//    index at 0. m_valid stays high, with no bubble. overrun is not set.
//  cap_ev in STREAM at any other time: the event is dropped, the buffer is unchanged, overrun is set
//    to 1. overrun clears only on reset.
//  Reset asserted mid-stream: all outputs go to 0 immediately (asynchronous); no partial resume.
//  busy = (state == STREAM).
// CONFIGURATION
//  GNN_ARGMAX_EN defined:
//    - On each accepted capture, class_vec[n] = ($signed(out1_n) > $signed(out0_n)). A tie gives 0.
//    - class_vec is registered in the same edge as the buffer, and class_vld pulses for that one cycle.
//  GNN_ARGMAX_EN undefined: class_vec and class_vld are tied to 0, and the ports remain present.
// STRUCTURE
//  gnn_pkg holds:
//    - localparams GNN_DATA_W=21, GNN_NUM_NODES=4, GNN_NUM_OUT=2
//    - typedef gnn_word_t (logic signed [GNN_DATA_W-1:0])
//    - typedef enum strm_state_t {IDLE, STREAM}
//  One sub-module: gnn_argmax2 (combinational signed 2-way compare; instanced per node, only under
//  GNN_ARGMAX_EN).
// TESTING
//  1 Reset, then all res_rdy rising with words 0..7 set to +1,-2,+3,-4,+5,-6,+7,-8 and m_ready=1:
//    - 8 beats appear on consecutive clocks, starting 1 clk after cap_ev, in that order.
//    - m_last is high only on -8; busy then drops.
//  2 Same data with m_ready toggled 1,0,0,1,...: held beats are stable while stalled, and 8 beats
//    are still delivered in order.
//  3 Extremes 0x0FFFFF (+1048575) and 0x100000 (-1048576) on words 0 and 1: values pass bit-exact
//    and signed.
//  4 Second res_rdy rising edge at beat 3: overrun=1, and the stream still completes with the first
//    data. Repeat with the rising edge on the last beat: new stream starts with no bubble, overrun
//    stays 0.
//  5 rst_n low after beat 4: m_valid, busy and overrun are 0 at once. After release, a new capture
//    streams from n0o0.
//  6 GNN_ARGMAX_EN with node pairs (3,5), (5,3), (-1,-1), (-7,2): class_vec=4'b1001, and class_vld
//    pulses once. Without the macro, class_vec and class_vld stay 0.

Source files
------------

// File: rtl/gnn_pkg.sv
// Shared types and sizing for the GNN layer-2 result streamer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gnn_pkg;

    localparam int GNN_DATA_W    = 21;
    localparam int GNN_NUM_NODES = 4;
    localparam int GNN_NUM_OUT   = 2;

    typedef logic signed [GNN_DATA_W-1:0] gnn_word_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } strm_state_t;

endpackage

// File: rtl/gnn_argmax2.sv
// Two-way signed compare: gt=1 when out1 is strictly greater than out0 (a tie gives 0).
// Latency: combinational.
// Backpressure: none.
module gnn_argmax2 #(
    parameter int DATA_W = 21
) (
    input  logic [DATA_W-1:0] out0,
    input  logic [DATA_W-1:0] out1,
    output logic              gt
);

    assign gt = ($signed(out1) > $signed(out0));

endmodule

// File: rtl/gnn_result_streamer.sv
// Captures NUM_NODES x NUM_OUT MAC results on the rising edge of "all ready" and streams them out one word per beat.
// Latency: first beat valid 1 clk after the capture event; 8 beats in 8 clocks when there are no stalls.
// Backpressure: m_ready low holds the current beat stable. Captures arriving mid-stream are dropped and set sticky overrun.
// Optional per-node argmax labels are built only when GNN_ARGMAX_EN is defined; otherwise class_vec/class_vld are 0.
module gnn_result_streamer
    import gnn_pkg::*;
#(
    parameter int DATA_W    = GNN_DATA_W,
    parameter int NUM_NODES = GNN_NUM_NODES,
    parameter int NUM_OUT   = GNN_NUM_OUT
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_NODES*NUM_OUT*DATA_W-1:0]  res_data,
    input  logic [NUM_NODES*NUM_OUT-1:0]         res_rdy,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [DATA_W-1:0]                    m_data,
    output logic [$clog2(NUM_NODES)-1:0]         m_node,
    output logic [$clog2(NUM_OUT)-1:0]           m_out,
    output logic                                 m_last,
    output logic                                 busy,
    output logic                                 overrun,
    output logic [NUM_NODES-1:0]                 class_vec,
    output logic                                 class_vld
);

    localparam int NUM_WORDS = NUM_NODES * NUM_OUT;
    localparam int IDX_W     = $clog2(NUM_WORDS);
    localparam int NODE_W    = $clog2(NUM_NODES);
    localparam int OUT_W     = $clog2(NUM_OUT);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [IDX_W-1:0] NOUT_IDX = IDX_W'(NUM_OUT);

    strm_state_t       state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] buf_q [NUM_WORDS];
    logic              all_q;
    logic              overrun_q;

    logic all_rdy;
    logic cap_ev;
    logic streaming;
    logic at_last;
    logic beat;
    logic last_beat;
    logic cap_acc;
    logic cap_drop;

    assign all_rdy   = &res_rdy;
    assign cap_ev    = all_rdy & ~all_q;
    assign streaming = (state_q == STREAM);
    assign at_last   = (idx_q == LAST_IDX);
    assign beat      = streaming & m_ready;
    assign last_beat = beat & at_last;
    // A capture landing exactly on the final beat is chained into a new stream with no bubble.
    assign cap_acc   = cap_ev & (~streaming | last_beat);
    assign cap_drop  = cap_ev & streaming & ~last_beat;

    // Output mux is a pure function of the held index, so a stall cannot disturb the beat.
    assign m_valid = streaming;
    assign busy    = streaming;
    assign m_data  = streaming ? buf_q[idx_q] : '0;
    assign m_node  = streaming ? NODE_W'(idx_q / NOUT_IDX) : '0;
    assign m_out   = streaming ? OUT_W'(idx_q % NOUT_IDX) : '0;
    assign m_last  = streaming & at_last;
    assign overrun = overrun_q;

    // Control: edge detect on all-ready, stream FSM, beat index and sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            all_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            all_q <= all_rdy;
            if (cap_drop) begin
                overrun_q <= 1'b1;
            end
            if (cap_acc) begin
                state_q <= STREAM;
                idx_q   <= '0;
            end else if (last_beat) begin
                state_q <= IDLE;
                idx_q   <= '0;
            end else if (beat) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    // Result buffer: loaded only on an accepted capture, otherwise held for the whole stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                buf_q[k] <= '0;
            end
        end else if (cap_acc) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                buf_q[k] <= res_data[k*DATA_W +: DATA_W];
            end
        end
    end

`ifdef GNN_ARGMAX_EN
    logic [NUM_NODES-1:0] node_gt;
    logic [NUM_NODES-1:0] class_q;
    logic                 class_vld_q;

    for (genvar n = 0; n < NUM_NODES; n++) begin : g_argmax
        gnn_argmax2 #(
            .DATA_W (DATA_W)
        ) u_argmax (
            .out0 (res_data[(n*NUM_OUT)*DATA_W +: DATA_W]),
            .out1 (res_data[(n*NUM_OUT+1)*DATA_W +: DATA_W]),
            .gt   (node_gt[n])
        );
    end

    // Labels are sampled from the same res_data that goes into the buffer, on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            class_q     <= '0;
            class_vld_q <= 1'b0;
        end else begin
            class_vld_q <= cap_acc;
            if (cap_acc) begin
                class_q <= node_gt;
            end
        end
    end

    assign class_vec = class_q;
    assign class_vld = class_vld_q;
`else
    assign class_vec = '0;
    assign class_vld = 1'b0;
`endif

endmodule

// File: tb/tb_gnn_result_streamer.sv
// Directed bench for gnn_result_streamer: ordering, stalls, extremes, overrun, async reset, argmax labels.
// Latency: checks first beat 1 clk after the capture event.
// Backpressure: exercises m_ready stall patterns and mid-stream capture events.
module tb_gnn_result_streamer;

    logic               clk;
    logic               rst_n;
    logic [167:0]       res_data;
    logic [7:0]         res_rdy;
    logic               m_valid;
    logic               m_ready;
    logic signed [20:0] m_data;
    logic [1:0]         m_node;
    logic               m_out;
    logic               m_last;
    logic               busy;
    logic               overrun;
    logic [3:0]         class_vec;
    logic               class_vld;

    int tests = 0;
    int fails = 0;

    int DA [8] = '{1, -2, 3, -4, 5, -6, 7, -8};
    int DB [8] = '{10, -20, 30, -40, 50, -60, 70, -80};
    int DX [8] = '{1048575, -1048576, 0, 1, -1, 2, -2, 3};
    int DC [8] = '{3, 5, 5, 3, -1, -1, -7, 2};

    gnn_result_streamer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .res_data  (res_data),
        .res_rdy   (res_rdy),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_node    (m_node),
        .m_out     (m_out),
        .m_last    (m_last),
        .busy      (busy),
        .overrun   (overrun),
        .class_vec (class_vec),
        .class_vld (class_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_words(input int w [8]);
        for (int k = 0; k < 8; k++) begin
            res_data[k*21 +: 21] = 21'(w[k]);
        end
    endtask

    task automatic check_beat(input string tag, input int i, input int w [8]);
        chk($sformatf("%s_b%0d_valid", tag, i), 32'(m_valid), 1);
        chk($sformatf("%s_b%0d_data", tag, i), 32'(m_data), w[i]);
        chk($sformatf("%s_b%0d_node", tag, i), 32'(m_node), i / 2);
        chk($sformatf("%s_b%0d_out", tag, i), 32'(m_out), i % 2);
        chk($sformatf("%s_b%0d_last", tag, i), 32'(m_last), (i == 7) ? 1 : 0);
    endtask

    // Drop flags, load data, raise flags; returns with the first beat on the outputs.
    task automatic capture(input int w [8]);
        res_rdy = 8'h00;
        set_words(w);
        tick();
        res_rdy = 8'hFF;
        tick();
    endtask

    initial begin
        int k;
        rst_n    = 1'b0;
        res_rdy  = 8'h00;
        res_data = '0;
        m_ready  = 1'b0;
        tick();
        tick();

        // Reset values
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_data", 32'(m_data), 0);
        chk("rst_last", 32'(m_last), 0);
        chk("rst_class_vec", 32'(class_vec), 0);
        chk("rst_class_vld", 32'(class_vld), 0);
        rst_n = 1'b1;
        tick();

        // Test 1: basic stream, no stalls
        m_ready = 1'b1;
        set_words(DA);
        res_rdy = 8'hFF;
        chk("t1_pre_valid", 32'(m_valid), 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            check_beat("t1", i, DA);
            tick();
        end
        chk("t1_busy_end", 32'(busy), 0);
        chk("t1_valid_end", 32'(m_valid), 0);
        chk("t1_overrun", 32'(overrun), 0);

        // Test 2: m_ready pattern 1,0,0 repeating
        capture(DA);
        k = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            m_ready = (c % 3 == 0);
            check_beat("t2", k, DA);
            tick();
            if (m_ready) k++;
        end
        chk("t2_count", k, 8);
        chk("t2_busy_end", 32'(busy), 0);
        m_ready = 1'b1;

        // Test 3: signed extremes
        capture(DX);
        for (int i = 0; i < 8; i++) begin
            check_beat("t3", i, DX);
            tick();
        end
        chk("t3_busy_end", 32'(busy), 0);

        // Test 4a: new capture at beat 3 is dropped and sets overrun
        capture(DA);
        for (int i = 0; i < 8; i++) begin
            check_beat("t4a", i, DA);
            if (i == 3) begin
                res_rdy = 8'hFF;
                set_words(DB);
            end else begin
                res_rdy = 8'h00;
            end
            tick();
            if (i == 3) chk("t4a_overrun_set", 32'(overrun), 1);
        end
        chk("t4a_busy_end", 32'(busy), 0);
        chk("t4a_overrun_sticky", 32'(overrun), 1);

        // Test 5: async reset mid-stream, then a clean restart
        capture(DB);
        for (int i = 0; i < 5; i++) begin
            check_beat("t5", i, DB);
            tick();
        end
        #2;
        rst_n   = 1'b0;
        res_rdy = 8'h00;
        #1;
        chk("t5_rst_valid", 32'(m_valid), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_overrun", 32'(overrun), 0);
        chk("t5_rst_data", 32'(m_data), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_idle_after_rst", 32'(busy), 0);
        capture(DB);
        for (int i = 0; i < 8; i++) begin
            check_beat("t5r", i, DB);
            tick();
        end
        chk("t5r_busy_end", 32'(busy), 0);

        // Test 4b: capture coinciding with the last beat chains with no bubble
        capture(DA);
        for (int i = 0; i < 8; i++) begin
            check_beat("t4b", i, DA);
            if (i == 7) begin
                res_rdy = 8'hFF;
                set_words(DB);
            end else begin
                res_rdy = 8'h00;
            end
            tick();
        end
        chk("t4b_overrun", 32'(overrun), 0);
        for (int i = 0; i < 8; i++) begin
            check_beat("t4b2", i, DB);
            tick();
        end
        chk("t4b2_busy_end", 32'(busy), 0);
        chk("t4b2_overrun", 32'(overrun), 0);

        // Test 6: argmax labels
        capture(DC);
`ifdef GNN_ARGMAX_EN
        chk("t6_class_vld_pulse", 32'(class_vld), 1);
        chk("t6_class_vec", 32'(class_vec), 9);
`else
        chk("t6_class_vld_off", 32'(class_vld), 0);
        chk("t6_class_vec_off", 32'(class_vec), 0);
`endif
        check_beat("t6", 0, DC);
        tick();
        chk("t6_class_vld_low", 32'(class_vld), 0);
`ifdef GNN_ARGMAX_EN
        chk("t6_class_vec_hold", 32'(class_vec), 9);
`else
        chk("t6_class_vec_hold", 32'(class_vec), 0);
`endif
        for (int i = 1; i < 8; i++) begin
            check_beat("t6", i, DC);
            tick();
        end
        chk("t6_busy_end", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
